// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, state type,
// the divide-by-zero quotient pattern and the full-adder / mux cells used by
// the carry-select subtractor.
package div_pkg;

    // Legacy-compatible state encodings; the enum below is built on them.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // Quotient reported for a zero divisor (all ones, truncated to W by the user).
    localparam int unsigned QUOT_DBZ_W = 64;
    localparam logic [QUOT_DBZ_W-1:0] QUOT_DBZ = '1;

    // Bits per carry-select slice, matching the multiplier tree adder slices.
    localparam int unsigned CSEL_SLICE = 3;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // 2:1 mux cell.
    function automatic logic mux_cell(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/csel_sub.sv
// Carry-select subtractor: diff = a - b computed as a + ~b + 1.
// Each 3-bit slice holds two ripple chains of full adders (carry-in 0 and 1)
// and the incoming slice carry selects between them.
// Ports:
//   a        minuend, N bits
//   b        subtrahend, N bits
//   diff     a - b modulo 2^N
//   borrow_n carry out of the top bit; 1 means a >= b (no borrow)
module csel_sub
    import div_pkg::*;
#(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_n
);

    localparam int unsigned NS = (N + CSEL_SLICE - 1) / CSEL_SLICE;

    logic [N:1]  w_k0;  // ripple carries assuming slice carry-in 0
    logic [N:1]  w_k1;  // ripple carries assuming slice carry-in 1
    logic [NS:0] w_c;   // selected carries between slices

    // The +1 of two's-complement negation enters as the first slice carry.
    assign w_c[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        localparam int unsigned S = i / CSEL_SLICE;
        logic w_cin0;
        logic w_cin1;
        logic w_s0;
        logic w_s1;

        // Slice boundary: both speculative chains restart with fixed carries.
        if ((i % CSEL_SLICE) == 0) begin : g_head
            assign w_cin0 = 1'b0;
            assign w_cin1 = 1'b1;
        end else begin : g_body
            assign w_cin0 = w_k0[i];
            assign w_cin1 = w_k1[i];
        end

        assign {w_k0[i+1], w_s0} = fa_cell(a[i], ~b[i], w_cin0);
        assign {w_k1[i+1], w_s1} = fa_cell(a[i], ~b[i], w_cin1);
        assign diff[i] = mux_cell(w_c[S], w_s0, w_s1);

        // Last bit of a slice produces the carry into the next slice.
        if (((i % CSEL_SLICE) == (CSEL_SLICE - 1)) || (i == N - 1)) begin : g_tail
            assign w_c[S+1] = mux_cell(w_c[S], w_k0[i+1], w_k1[i+1]);
        end
    end

    assign borrow_n = w_c[NS];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider with start/busy/done handshake.
// One trial subtraction per RUN cycle; results are held until the next
// accepted start. A zero divisor completes in one edge with all-ones quotient.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request a division (honoured in IDLE or DONE)
//   dividend, divisor   operands, sampled on the accepting edge
//   busy                high while iterating
//   done                one-cycle completion pulse
//   quotient, remainder held results
//   div_by_zero         set with done when the divisor was zero
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    state_t        r_state;
    logic [W-1:0]  r_a;     // dividend shifting out / quotient shifting in
    logic [W-1:0]  r_div;
    logic [W:0]    r_p;     // partial remainder
    logic [CW-1:0] r_cnt;

    state_t        w_nxt_state;
    logic [W-1:0]  w_nxt_a;
    logic [W-1:0]  w_nxt_div;
    logic [W:0]    w_nxt_p;
    logic [CW-1:0] w_nxt_cnt;
    logic          w_nxt_busy;
    logic          w_nxt_done;
    logic [W-1:0]  w_nxt_q;
    logic [W-1:0]  w_nxt_r;
    logic          w_nxt_dbz;

    logic [W:0]    w_p_shift;
    logic [W:0]    w_diff;
    logic          w_no_borrow;
    logic          w_take;
    logic [W:0]    w_p_iter;
    logic [W-1:0]  w_a_iter;

    // One restoring step: shift in the next dividend bit and try the divisor.
    assign w_p_shift = {r_p[W-1:0], r_a[W-1]};

    csel_sub #(
        .N(W + 1)
    ) u_sub (
        .a       (w_p_shift),
        .b       ({1'b0, r_div}),
        .diff    (w_diff),
        .borrow_n(w_no_borrow)
    );

    // A set top bit in P means the shifted value exceeds any divisor, so the
    // subtraction must succeed; the restoring invariant keeps that bit at 0.
    assign w_take   = w_no_borrow | r_p[W];
    assign w_p_iter = w_take ? w_diff : w_p_shift;
    assign w_a_iter = {r_a[W-2:0], w_take};

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_a     = r_a;
        w_nxt_div   = r_div;
        w_nxt_p     = r_p;
        w_nxt_cnt   = r_cnt;
        w_nxt_busy  = 1'b0;
        w_nxt_done  = 1'b0;
        w_nxt_q     = quotient;
        w_nxt_r     = remainder;
        w_nxt_dbz   = div_by_zero;

        case (r_state)
            IDLE, DONE: begin
                w_nxt_state = IDLE;
                if (start) begin
                    w_nxt_a   = dividend;
                    w_nxt_div = divisor;
                    w_nxt_p   = '0;
                    w_nxt_cnt = '0;
                    if (divisor != '0) begin
                        w_nxt_state = RUN;
                        w_nxt_busy  = 1'b1;
                    end else begin
                        w_nxt_state = DONE;
                        w_nxt_done  = 1'b1;
                        w_nxt_q     = W'(QUOT_DBZ);
                        w_nxt_r     = dividend;
                        w_nxt_dbz   = 1'b1;
                    end
                end
            end

            RUN: begin
                w_nxt_a   = w_a_iter;
                w_nxt_p   = w_p_iter;
                w_nxt_cnt = r_cnt + CW'(1);
                if (r_cnt == CW'(W - 1)) begin
                    w_nxt_state = DONE;
                    w_nxt_done  = 1'b1;
                    w_nxt_q     = w_a_iter;
                    w_nxt_r     = w_p_iter[W-1:0];
                    w_nxt_dbz   = 1'b0;
                end else begin
                    w_nxt_busy = 1'b1;
                end
            end

            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_div       <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_a         <= w_nxt_a;
            r_div       <= w_nxt_div;
            r_p         <= w_nxt_p;
            r_cnt       <= w_nxt_cnt;
            busy        <= w_nxt_busy;
            done        <= w_nxt_done;
            quotient    <= w_nxt_q;
            remainder   <= w_nxt_r;
            div_by_zero <= w_nxt_dbz;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=8): a transaction-level model using
// plain / and % predicts every output each cycle; directed cases add literal
// expectations, then a sweep checks the division identity and latency.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_chk = 0;
    int n_pass = 0;

    seq_divider #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: a division finishes W edges after acceptance.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] m_pq = '0;
    logic [W-1:0] m_pr = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            m_q = '0; m_r = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_q = m_pq; m_r = m_pr; m_dbz = 1'b0;
                end
            end else if (start === 1'b1) begin
                if (divisor == '0) begin
                    m_done = 1'b1; m_q = '1; m_r = dividend; m_dbz = 1'b1;
                end else begin
                    m_left = W;
                    m_busy = 1'b1;
                    m_pq = W'(int'(dividend) / int'(divisor));
                    m_pr = W'(int'(dividend) % int'(divisor));
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_quotient", 32'(quotient), 32'(m_q));
        check("cyc_remainder", 32'(remainder), 32'(m_r));
        check("cyc_div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end

    // Drive start for one cycle from the current negedge.
    task automatic start_now(input logic [W-1:0] dd, input logic [W-1:0] dv);
        start = 1'b1; dividend = dd; divisor = dv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start(input logic [W-1:0] dd, input logic [W-1:0] dv);
        @(negedge clk);
        start_now(dd, dv);
    endtask

    // Wait (bounded) for done; lat counts edges after the accepting edge.
    task automatic wait_done(input int maxc, output int lat, output int nb);
        lat = 0;
        nb = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < maxc) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) nb++;
        end
        if (done !== 1'b1) begin
            n_chk++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, lat);
        end
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, nd;
        logic [W-1:0] dd, dv;
        logic [W-1:0] dd_list [7] = '{8'd0, 8'd255, 8'd254, 8'd1, 8'd3, 8'd255, 8'd128};
        logic [W-1:0] dv_list [7] = '{8'd1, 8'd255, 8'd255, 8'd255, 8'd200, 8'd2, 8'd1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        rst_n = 1'b1;

        // 100 / 7
        do_start(8'd100, 8'd7);
        wait_done(20, lat, nb);
        check("t1_latency", 32'(lat), 8);
        check("t1_busy_cycles", 32'(nb), 8);
        check("t1_quotient", 32'(quotient), 14);
        check("t1_remainder", 32'(remainder), 2);
        check("t1_dbz", 32'(div_by_zero), 0);
        check("t1_model_q", 32'(m_q), 14);
        check("t1_model_r", 32'(m_r), 2);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(done), 0);
        check("t1_hold_q", 32'(quotient), 14);

        // 255 / 1, then 5 / 9 issued in the DONE cycle
        do_start(8'd255, 8'd1);
        wait_done(20, lat, nb);
        check("t2_quotient", 32'(quotient), 255);
        check("t2_remainder", 32'(remainder), 0);
        start_now(8'd5, 8'd9);
        check("t2b_accepted_busy", 32'(busy), 1);
        wait_done(20, lat, nb);
        check("t2b_latency", 32'(lat), 8);
        check("t2b_quotient", 32'(quotient), 0);
        check("t2b_remainder", 32'(remainder), 5);

        // 200 / 0
        do_start(8'd200, 8'd0);
        wait_done(3, lat, nb);
        check("t3_latency", 32'(lat), 0);
        check("t3_busy_cycles", 32'(nb), 0);
        check("t3_quotient", 32'(quotient), 255);
        check("t3_remainder", 32'(remainder), 200);
        check("t3_dbz", 32'(div_by_zero), 1);
        check("t3_model_dbz", 32'(m_dbz), 1);

        // start during RUN is ignored; operand changes have no effect
        do_start(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        start_now(8'd9, 8'd3);
        wait_done(20, lat, nb);
        check("t4_latency_rest", 32'(lat), 5);
        check("t4_quotient", 32'(quotient), 14);
        check("t4_remainder", 32'(remainder), 2);
        count_dones(12, nd);
        check("t4_no_second_done", 32'(nd), 0);

        // reset in the middle of RUN
        do_start(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_quotient", 32'(quotient), 0);
        check("t5_remainder", 32'(remainder), 0);
        rst_n = 1'b1;
        count_dones(12, nd);
        check("t5_no_done", 32'(nd), 0);
        do_start(8'd50, 8'd5);
        wait_done(20, lat, nb);
        check("t5_quotient_50_5", 32'(quotient), 10);
        check("t5_remainder_50_5", 32'(remainder), 0);

        // sweep: directed corner pairs first, then random
        for (int n = 0; n < 1000; n++) begin
            if (n < 7) begin
                dd = dd_list[n]; dv = dv_list[n];
            end else begin
                dd = W'($urandom_range(0, 255));
                dv = W'($urandom_range(1, 255));
            end
            do_start(dd, dv);
            wait_done(20, lat, nb);
            check("sw_latency", 32'(lat), 8);
            check("sw_identity", 32'(int'(quotient) * int'(dv) + int'(remainder)), 32'(dd));
            check("sw_rem_lt_div", 32'(remainder < dv), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
